// File: rtl/counter_updown_mod_pkg.sv
// -----------------------------------------------------------------------------
// counter_updown_mod_pkg
// Shared constants and helpers for the up/down counter and its prescaler.
//   clog2     : ceiling log2 for sizing registers from parameters
//   MODE_*    : values of the SATURATE parameter
//   DIR_*     : values of the up_dn input
// -----------------------------------------------------------------------------
package counter_updown_mod_pkg;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    localparam logic DIR_UP = 1'b1;
    localparam logic DIR_DN = 1'b0;

    // Ceiling log2; returns 0 for n <= 1.
    function automatic int clog2(input int n);
        int r;
        int v;
        r = 0;
        v = n - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/counter_updown_mod_prescaler.sv
// -----------------------------------------------------------------------------
// counter_prescaler
// Divides enabled cycles by PRESCALE and emits a one-cycle step strobe.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : advance enable; en=0 freezes the prescale state
//   sync_clr : synchronous return to state 0 (no strobe while asserted)
//   tick     : step strobe, high when en=1 in the last prescale state
// -----------------------------------------------------------------------------
module counter_prescaler
    import counter_updown_mod_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    // At least one bit so PRESCALE=1 still has a legal register.
    localparam int PW = (clog2(PRESCALE) < 1) ? 1 : clog2(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] pre_q;
    logic [PW-1:0] pre_d;
    logic          at_last;

    assign at_last = (pre_q == LAST);
    assign tick    = en & ~sync_clr & at_last;

    always_comb begin
        pre_d = pre_q;
        if (sync_clr) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = at_last ? '0 : pre_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/counter_updown_mod.sv
// -----------------------------------------------------------------------------
// counter_updown_mod
// WIDTH-bit up/down counter, modulo MAX+1, with wrap or saturate at the
// boundaries, synchronous clear/load, clock-enable prescaler, terminal-count
// flag and a registered boundary-step pulse.
// Ports:
//   clk      : rising-edge clock
//   rst      : asynchronous active-low reset
//   en       : count enable, also gates the prescaler
//   up_dn    : 1 = count up, 0 = count down
//   clr      : synchronous clear (highest priority)
//   load     : synchronous load of load_val, clamped to MAX
//   load_val : value to load
//   count    : registered count
//   tc       : count sits at the boundary for the current direction
//   ovf      : one-cycle pulse after a step taken from a boundary
// -----------------------------------------------------------------------------
module counter_updown_mod
    import counter_updown_mod_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX      = 2**WIDTH - 1,
    parameter int SATURATE = MODE_WRAP,
    parameter int PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_dn,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    // One extra bit so MAX = 2**WIDTH-1 and the load comparison never alias.
    localparam logic [WIDTH:0] MAX_X = (WIDTH+1)'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;
    logic             ovf_q;
    logic             ovf_d;
    logic             step;
    logic [WIDTH:0]   cnt_x;
    logic [WIDTH:0]   ld_x;
    logic [WIDTH-1:0] load_clamped;
    logic             at_max;
    logic             at_zero;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (step)
    );

    assign cnt_x        = {1'b0, count_q};
    assign ld_x         = {1'b0, load_val};
    assign at_max       = (cnt_x == MAX_X);
    assign at_zero      = (cnt_x == '0);
    assign load_clamped = (ld_x > MAX_X) ? WIDTH'(MAX_X) : load_val;

    always_comb begin
        count_d = count_q;
        ovf_d   = 1'b0;
        if (clr) begin
            count_d = '0;
        end else if (load) begin
            count_d = load_clamped;
        end else if (step) begin
            if (up_dn == DIR_UP) begin
                if (at_max) begin
                    count_d = (SATURATE == MODE_SAT) ? count_q : '0;
                    ovf_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(cnt_x + (WIDTH+1)'(1));
                end
            end else begin
                if (at_zero) begin
                    count_d = (SATURATE == MODE_SAT) ? count_q : WIDTH'(MAX_X);
                    ovf_d   = 1'b1;
                end else begin
                    count_d = WIDTH'(cnt_x - (WIDTH+1)'(1));
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign count = count_q;
    assign ovf   = ovf_q;
    // Not qualified by en or the prescaler: purely a view of the current count.
    assign tc    = ((up_dn == DIR_UP) & at_max) | ((up_dn == DIR_DN) & at_zero);

endmodule

// File: tb/tb_counter_updown_mod.sv
// Directed bench for counter_updown_mod: four instances cover wrap (MAX=9),
// saturate (MAX=9), prescale-by-3 (MAX=9) and full-width wrap (MAX=15).
module tb_counter_updown_mod;

    typedef struct packed {
        logic       en;
        logic       up_dn;
        logic       clr;
        logic       load;
        logic [3:0] load_val;
    } drv_t;

    logic clk;
    logic rst_n;
    drv_t iw, is, ip, ifl;

    logic [3:0] w_count, s_count, p_count, f_count;
    logic       w_tc, s_tc, p_tc, f_tc;
    logic       w_ovf, s_ovf, p_ovf, f_ovf;

    int total;
    int bad;

    counter_updown_mod #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(1)) u_w (
        .clk(clk), .rst(rst_n), .en(iw.en), .up_dn(iw.up_dn), .clr(iw.clr),
        .load(iw.load), .load_val(iw.load_val), .count(w_count), .tc(w_tc), .ovf(w_ovf));

    counter_updown_mod #(.WIDTH(4), .MAX(9), .SATURATE(1), .PRESCALE(1)) u_s (
        .clk(clk), .rst(rst_n), .en(is.en), .up_dn(is.up_dn), .clr(is.clr),
        .load(is.load), .load_val(is.load_val), .count(s_count), .tc(s_tc), .ovf(s_ovf));

    counter_updown_mod #(.WIDTH(4), .MAX(9), .SATURATE(0), .PRESCALE(3)) u_p (
        .clk(clk), .rst(rst_n), .en(ip.en), .up_dn(ip.up_dn), .clr(ip.clr),
        .load(ip.load), .load_val(ip.load_val), .count(p_count), .tc(p_tc), .ovf(p_ovf));

    counter_updown_mod #(.WIDTH(4), .MAX(15), .SATURATE(0), .PRESCALE(1)) u_f (
        .clk(clk), .rst(rst_n), .en(ifl.en), .up_dn(ifl.up_dn), .clr(ifl.clr),
        .load(ifl.load), .load_val(ifl.load_val), .count(f_count), .tc(f_tc), .ovf(f_ovf));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) else begin
            bad = bad + 1;
            $display("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One rising edge, then settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int pexp [11] = '{0, 0, 1, 1, 1, 2, 2, 2, 2, 2, 3};
    logic pen [11] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 1, 1};

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        iw  = '0;
        is  = '0;
        ip  = '0;
        ifl = '0;

        // Reset state
        #2;
        chk("rst_count", 32'(w_count), 0);
        chk("rst_ovf", 32'(w_ovf), 0);
        chk("rst_tc_dn", 32'(w_tc), 1);
        rst_n = 1'b1;
        iw.en = 1'b1;
        iw.up_dn = 1'b1;
        #1;
        chk("post_rst_count", 32'(w_count), 0);
        chk("post_rst_tc_up", 32'(w_tc), 0);
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk("up_seq", 32'(w_count), 32'(i));
        end

        // Asynchronous reset mid-count, no edge needed
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_count", 32'(w_count), 0);
        chk("async_rst_ovf", 32'(w_ovf), 0);
        rst_n = 1'b1;
        tick();
        chk("restart_1", 32'(w_count), 1);
        tick();
        chk("restart_2", 32'(w_count), 2);

        // Wrap up from 8
        iw.load = 1'b1;
        iw.load_val = 4'd8;
        tick();
        chk("wrap_ld8", 32'(w_count), 8);
        chk("wrap_ld8_ovf", 32'(w_ovf), 0);
        iw.load = 1'b0;
        tick();
        chk("wrap_up_9", 32'(w_count), 9);
        chk("wrap_up_9_tc", 32'(w_tc), 1);
        chk("wrap_up_9_ovf", 32'(w_ovf), 0);
        tick();
        chk("wrap_up_0", 32'(w_count), 0);
        chk("wrap_up_0_ovf", 32'(w_ovf), 1);
        chk("wrap_up_0_tc", 32'(w_tc), 0);
        tick();
        chk("wrap_up_1", 32'(w_count), 1);
        chk("wrap_up_1_ovf", 32'(w_ovf), 0);

        // Wrap down from 1
        iw.up_dn = 1'b0;
        tick();
        chk("wrap_dn_0", 32'(w_count), 0);
        chk("wrap_dn_0_tc", 32'(w_tc), 1);
        chk("wrap_dn_0_ovf", 32'(w_ovf), 0);
        tick();
        chk("wrap_dn_9", 32'(w_count), 9);
        chk("wrap_dn_9_ovf", 32'(w_ovf), 1);
        tick();
        chk("wrap_dn_8", 32'(w_count), 8);
        chk("wrap_dn_8_ovf", 32'(w_ovf), 0);

        // Load clamp, clr over load, load over step, en=0 hold
        iw.en = 1'b0;
        iw.load = 1'b1;
        iw.load_val = 4'd12;
        tick();
        chk("load_clamp", 32'(w_count), 9);
        iw.clr = 1'b1;
        iw.load_val = 4'd5;
        tick();
        chk("clr_over_load", 32'(w_count), 0);
        iw.clr = 1'b0;
        iw.en = 1'b1;
        iw.up_dn = 1'b1;
        iw.load_val = 4'd3;
        tick();
        chk("load_over_step", 32'(w_count), 3);
        iw.load = 1'b0;
        tick();
        chk("step_after_load", 32'(w_count), 4);
        iw.en = 1'b0;
        tick();
        chk("en0_hold", 32'(w_count), 4);

        // Saturate up from 8
        is.load = 1'b1;
        is.load_val = 4'd8;
        tick();
        chk("sat_ld8", 32'(s_count), 8);
        is.load = 1'b0;
        is.en = 1'b1;
        is.up_dn = 1'b1;
        tick();
        chk("sat_up_9", 32'(s_count), 9);
        chk("sat_up_9_ovf", 32'(s_ovf), 0);
        chk("sat_up_9_tc", 32'(s_tc), 1);
        tick();
        chk("sat_hold_9a", 32'(s_count), 9);
        chk("sat_hold_9a_ovf", 32'(s_ovf), 1);
        tick();
        chk("sat_hold_9b", 32'(s_count), 9);
        chk("sat_hold_9b_ovf", 32'(s_ovf), 1);
        is.up_dn = 1'b0;
        tick();
        chk("sat_dn_8", 32'(s_count), 8);
        chk("sat_dn_8_ovf", 32'(s_ovf), 0);

        // Saturate down at 0
        is.load = 1'b1;
        is.load_val = 4'd0;
        tick();
        chk("sat_ld0", 32'(s_count), 0);
        chk("sat_ld0_tc", 32'(s_tc), 1);
        is.load = 1'b0;
        tick();
        chk("sat_hold_0", 32'(s_count), 0);
        chk("sat_hold_0_ovf", 32'(s_ovf), 1);
        chk("sat_hold_0_tc", 32'(s_tc), 1);
        is.en = 1'b0;
        tick();
        chk("sat_ovf_drop", 32'(s_ovf), 0);

        // Prescale by 3 with a 2-cycle en gap mid-prescale
        ip.up_dn = 1'b1;
        for (int i = 0; i < 11; i++) begin
            ip.en = pen[i];
            tick();
            chk($sformatf("pre_e%0d", i + 1), 32'(p_count), 32'(pexp[i]));
        end
        ip.en = 1'b0;

        // Full width: MAX=15
        ifl.load = 1'b1;
        ifl.load_val = 4'd15;
        tick();
        chk("fw_ld15_noclamp", 32'(f_count), 15);
        ifl.load_val = 4'd14;
        tick();
        chk("fw_ld14", 32'(f_count), 14);
        ifl.load = 1'b0;
        ifl.en = 1'b1;
        ifl.up_dn = 1'b1;
        chk("fw_14_tc", 32'(f_tc), 0);
        tick();
        chk("fw_15", 32'(f_count), 15);
        chk("fw_15_tc", 32'(f_tc), 1);
        chk("fw_15_ovf", 32'(f_ovf), 0);
        tick();
        chk("fw_0", 32'(f_count), 0);
        chk("fw_0_ovf", 32'(f_ovf), 1);
        tick();
        chk("fw_1", 32'(f_count), 1);
        chk("fw_1_ovf", 32'(f_ovf), 0);
        ifl.up_dn = 1'b0;
        tick();
        tick();
        chk("fw_dn_wrap_15", 32'(f_count), 15);
        chk("fw_dn_wrap_ovf", 32'(f_ovf), 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
